estacao_reserva_ula: RTL and testbench
======================================

Name: estacao_reserva_ula

Overview:
- Reservation station that sits directly upstream of the 16-bit ALU in the Tomasulo execution path.
- Accepts issued ALU instructions whose operands may still be pending on producer tags.
- Snoops the common data bus (CDB) to capture results as they are broadcast.
- Dispatches one operand-complete instruction at a time to the ALU through a registered valid/ready interface.

Parameters:
NUM_ENTRADAS, 4, number of station entries (2..8)
LARGURA_TAG, 3, tag width; tag 0 reserved = "value present / no producer"
LARGURA_DADO, 16, operand width; must match ALU operand width

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  synchronous, active-low reset
emite_valido  in  1  issue request this cycle
emite_pronto  out  1  at least one free entry (from registered state)
emite_codop  in  4  ALU opcode, passed through unchanged
emite_vj  in  LARGURA_DADO  operand1 value (meaningful when emite_qj==0)
emite_qj  in  LARGURA_TAG  operand1 producer tag, 0 = ready
emite_vk  in  LARGURA_DADO  operand2 value
emite_qk  in  LARGURA_TAG  operand2 producer tag, 0 = ready
emite_tag  in  LARGURA_TAG  destination tag of the instruction (nonzero)
cdb_valido  in  1  CDB broadcast valid
cdb_tag  in  LARGURA_TAG  broadcasting producer tag
cdb_dado  in  LARGURA_DADO  broadcast result
ula_valido  out  1  dispatch register holds an instruction for the ALU
ula_pronto  in  1  ALU accepts the instruction this cycle
ula_codop  out  4  dispatched opcode
ula_operando1  out  LARGURA_DADO  dispatched Vj
ula_operando2  out  LARGURA_DADO  dispatched Vk
ula_tag  out  LARGURA_TAG  dispatched destination tag
ocupadas  out  4  count of busy entries (0..NUM_ENTRADAS)

Behaviour:
- Reset: reset_n=0 at a rising edge clears all entry busy bits, ula_valido, ula_codop, ula_operando1/2, ula_tag and ocupadas to 0. It has priority over issue, CDB and dispatch. Mid-operation reset discards all contents, including an undelivered dispatch.
- Entry state: busy, codop, vj, qj, vk, qk, tag. An entry is ready when busy && qj==0 && qk==0.
- Issue:
  - emite_pronto = any entry not busy.
  - On emite_valido && emite_pronto, the lowest-index free entry is written at the edge.
  - emite_valido while emite_pronto=0 is ignored; no state changes.
- Issue-time bypass: if cdb_valido && cdb_tag!=0 && emite_qj==cdb_tag in the same cycle, the entry stores vj=cdb_dado, qj=0. The same rule applies independently to qk.
- CDB capture:
  - Each busy entry with qj==cdb_tag (cdb_tag!=0, cdb_valido=1) loads vj=cdb_dado and clears qj; the same for qk.
  - All matching entries update in the same cycle.
  - cdb_tag==0 is always ignored.
- Wake-up: readiness is evaluated from registered entry state only. An operand captured at edge N makes the entry dispatch-eligible for edge N+1.
- Dispatch:
  - The output register is loadable when ula_valido==0 or (ula_valido && ula_pronto).
  - When loadable and a ready entry exists, the lowest-index ready entry is copied into the ula_* outputs, ula_valido=1, and that entry's busy bit is cleared at the same edge.
  - When loadable and no entry is ready, ula_valido drops to 0 (after a handshake) and the ula_* data fields hold their last values.
  - While ula_valido && !ula_pronto, all ula_* outputs are stable.
- Entry reuse: an entry freed by dispatch at edge N is visible in emite_pronto after edge N. Issue and dispatch in the same cycle are allowed, and the issue uses a free entry from pre-edge state.
- ocupadas = registered busy-bit count, updated as +1 on issue, -1 on dispatch, unchanged on both.
- Latency: an instruction issued with both operands ready at edge 0 has ula_valido=1 after edge 1 (minimum 1 cycle issue-to-dispatch). It is delivered at the first edge with ula_pronto=1.
- Full: with all entries busy, emite_pronto=0. A dispatch at edge N raises emite_pronto after edge N.

Test Plan:
- Reset/basic: hold reset_n=0 2 cycles, release; issue codop=0, vj=0x0003, vk=0x0004, qj=qk=0, tag=1, ula_pronto=1 -> ula_valido=1 one cycle later with operands 0x0003/0x0004, tag 1; ocupadas returns to 0.
- CDB wake-up: issue codop=1, qj=5, vk=0x0010, qk=0; later cdb_valido=1, cdb_tag=5, cdb_dado=0x0020 -> ula_valido rises exactly one edge after capture, ula_operando1=0x0020, ula_operando2=0x0010.
- Bypass: issue qk=2 in the same cycle as cdb_tag=2, cdb_dado=0xBEEF -> entry dispatched next cycle with ula_operando2=0xBEEF, no further broadcast needed.
- Full/backpressure: ula_pronto=0, issue 5 instructions with qj=7 -> 4 accepted, emite_pronto=0, ocupadas=4, fifth ignored. Broadcast tag 7 -> ula_* holds entry 0 stable until ula_pronto=1, then entries 1..3 dispatch in index order, one per cycle.
- Simultaneous: full station, ula_pronto=1 with a dispatch and emite_valido=1 in the same cycle -> the dispatch frees an entry, the issue is accepted the next cycle, ocupadas never exceeds 4.
- Reset mid-operation: reset_n=0 while ula_valido=1 and 3 entries busy -> after the edge, ula_valido=0, ocupadas=0, emite_pronto=1.

Source files
------------

// File: rtl/estacao_reserva_ula.sv
// estacao_reserva_ula: ALU reservation station with CDB snooping and a registered dispatch port.
// Entries wait on producer tags; the lowest-index operand-complete entry feeds the ALU.
module estacao_reserva_ula #(
    parameter int NUM_ENTRADAS = 4,
    parameter int LARGURA_TAG  = 3,
    parameter int LARGURA_DADO = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    emite_valido,
    output logic                    emite_pronto,
    input  logic [3:0]              emite_codop,
    input  logic [LARGURA_DADO-1:0] emite_vj,
    input  logic [LARGURA_TAG-1:0]  emite_qj,
    input  logic [LARGURA_DADO-1:0] emite_vk,
    input  logic [LARGURA_TAG-1:0]  emite_qk,
    input  logic [LARGURA_TAG-1:0]  emite_tag,
    input  logic                    cdb_valido,
    input  logic [LARGURA_TAG-1:0]  cdb_tag,
    input  logic [LARGURA_DADO-1:0] cdb_dado,
    output logic                    ula_valido,
    input  logic                    ula_pronto,
    output logic [3:0]              ula_codop,
    output logic [LARGURA_DADO-1:0] ula_operando1,
    output logic [LARGURA_DADO-1:0] ula_operando2,
    output logic [LARGURA_TAG-1:0]  ula_tag,
    output logic [3:0]              ocupadas
);
    localparam int IW = $clog2(NUM_ENTRADAS);

    logic [NUM_ENTRADAS-1:0] busy;
    logic [3:0]              codop [NUM_ENTRADAS];
    logic [LARGURA_DADO-1:0] vj    [NUM_ENTRADAS];
    logic [LARGURA_DADO-1:0] vk    [NUM_ENTRADAS];
    logic [LARGURA_TAG-1:0]  qj    [NUM_ENTRADAS];
    logic [LARGURA_TAG-1:0]  qk    [NUM_ENTRADAS];
    logic [LARGURA_TAG-1:0]  tag   [NUM_ENTRADAS];

    logic          free_any, rdy_any, cdb_hit, emite, carrega, despacha;
    logic [IW-1:0] free_idx, rdy_idx;

    // Descending scan so the lowest index wins both selections.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        rdy_any  = 1'b0;
        rdy_idx  = '0;
        for (int i = NUM_ENTRADAS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            if (busy[i] && qj[i] == '0 && qk[i] == '0) begin
                rdy_any = 1'b1;
                rdy_idx = IW'(i);
            end
        end
    end

    assign emite_pronto = free_any;
    assign cdb_hit      = cdb_valido && cdb_tag != '0;
    assign emite        = emite_valido && free_any;
    assign carrega      = !ula_valido || ula_pronto;
    assign despacha     = carrega && rdy_any;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy          <= '0;
            ula_valido    <= 1'b0;
            ula_codop     <= '0;
            ula_operando1 <= '0;
            ula_operando2 <= '0;
            ula_tag       <= '0;
            ocupadas      <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRADAS; i++) begin
                if (busy[i] && cdb_hit && qj[i] == cdb_tag) begin
                    vj[i] <= cdb_dado;
                    qj[i] <= '0;
                end
                if (busy[i] && cdb_hit && qk[i] == cdb_tag) begin
                    vk[i] <= cdb_dado;
                    qk[i] <= '0;
                end
            end
            if (emite) begin
                busy[free_idx]  <= 1'b1;
                codop[free_idx] <= emite_codop;
                tag[free_idx]   <= emite_tag;
                vj[free_idx]    <= (cdb_hit && emite_qj == cdb_tag) ? cdb_dado : emite_vj;
                qj[free_idx]    <= (cdb_hit && emite_qj == cdb_tag) ? '0 : emite_qj;
                vk[free_idx]    <= (cdb_hit && emite_qk == cdb_tag) ? cdb_dado : emite_vk;
                qk[free_idx]    <= (cdb_hit && emite_qk == cdb_tag) ? '0 : emite_qk;
            end
            if (carrega) ula_valido <= rdy_any;
            if (despacha) begin
                busy[rdy_idx] <= 1'b0;
                ula_codop     <= codop[rdy_idx];
                ula_operando1 <= vj[rdy_idx];
                ula_operando2 <= vk[rdy_idx];
                ula_tag       <= tag[rdy_idx];
            end
            ocupadas <= ocupadas + 4'(emite) - 4'(despacha);
        end
    end
endmodule

// File: tb/tb_estacao_reserva_ula.sv
// tb_estacao_reserva_ula: directed and random stimulus against a per-cycle behavioural station model.
// Expected dispatches are queued by the model and popped by a monitor at each ALU handshake.
module tb_estacao_reserva_ula;
    localparam int N = 4;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        emite_valido, emite_pronto, cdb_valido, ula_valido, ula_pronto;
    logic [3:0]  emite_codop, ula_codop, ocupadas;
    logic [15:0] emite_vj, emite_vk, cdb_dado, ula_operando1, ula_operando2;
    logic [2:0]  emite_qj, emite_qk, emite_tag, cdb_tag, ula_tag;

    always #5 clk = ~clk;

    estacao_reserva_ula dut (
        .clk(clk), .reset_n(reset_n),
        .emite_valido(emite_valido), .emite_pronto(emite_pronto), .emite_codop(emite_codop),
        .emite_vj(emite_vj), .emite_qj(emite_qj), .emite_vk(emite_vk), .emite_qk(emite_qk),
        .emite_tag(emite_tag), .cdb_valido(cdb_valido), .cdb_tag(cdb_tag), .cdb_dado(cdb_dado),
        .ula_valido(ula_valido), .ula_pronto(ula_pronto), .ula_codop(ula_codop),
        .ula_operando1(ula_operando1), .ula_operando2(ula_operando2), .ula_tag(ula_tag),
        .ocupadas(ocupadas)
    );

    typedef struct {bit b; bit [3:0] op; bit [15:0] vj, vk; bit [2:0] qj, qk, tg;} ent_t;
    typedef struct {bit [3:0] op; bit [15:0] a, b; bit [2:0] tg;} out_t;

    ent_t m [N];
    ent_t o [N];
    out_t exp_q [$];
    out_t e;
    bit   m_uv, armed, hit;
    int   f, r, checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m[i].b);
        return c;
    endfunction

    // Reference: operands wait for tags, lowest ready slot goes out when the output slot is free.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) m[i].b = 0;
            m_uv = 0;
            exp_q.delete();
            armed = 1;
        end else if (armed) begin
            o = m;
            f = -1;
            r = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (!o[i].b) f = i;
                if (o[i].b && o[i].qj == 0 && o[i].qk == 0) r = i;
            end
            hit = cdb_valido && cdb_tag != 0;
            for (int i = 0; i < N; i++) begin
                if (m[i].b && hit && m[i].qj == cdb_tag) begin m[i].vj = cdb_dado; m[i].qj = 0; end
                if (m[i].b && hit && m[i].qk == cdb_tag) begin m[i].vk = cdb_dado; m[i].qk = 0; end
            end
            if (emite_valido && f >= 0) begin
                m[f] = '{1, emite_codop, emite_vj, emite_vk, emite_qj, emite_qk, emite_tag};
                if (hit && emite_qj == cdb_tag) begin m[f].vj = cdb_dado; m[f].qj = 0; end
                if (hit && emite_qk == cdb_tag) begin m[f].vk = cdb_dado; m[f].qk = 0; end
            end
            if (!m_uv || ula_pronto) begin
                if (r >= 0) begin
                    exp_q.push_back('{o[r].op, o[r].vj, o[r].vk, o[r].tg});
                    m[r].b = 0;
                    m_uv = 1;
                end else m_uv = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("ula_valido", ula_valido, m_uv);
            chk("ocupadas", ocupadas, busy_count());
            chk("emite_pronto", emite_pronto, busy_count() < N);
            if (ula_valido && ula_pronto) begin
                if (exp_q.size() == 0) chk("dispatch_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("dispatch", {ula_codop, ula_operando1, ula_operando2, ula_tag},
                        {e.op, e.a, e.b, e.tg});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        emite_valido = 0;
        cdb_valido = 0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] vj, input logic [2:0] qj,
                         input logic [15:0] vk, input logic [2:0] qk, input logic [2:0] tg);
        emite_valido = 1;
        emite_codop = op;
        emite_vj = vj;
        emite_qj = qj;
        emite_vk = vk;
        emite_qk = qk;
        emite_tag = tg;
    endtask

    task automatic bcast(input logic [2:0] tg, input logic [15:0] d);
        cdb_valido = 1;
        cdb_tag = tg;
        cdb_dado = d;
    endtask

    initial begin
        idle();
        issue(0, 0, 0, 0, 0, 1);
        emite_valido = 0;
        cdb_tag = 0;
        cdb_dado = 0;
        ula_pronto = 1;
        tick();
        tick();
        chk("reset_ula", {ula_valido, ula_codop, ula_operando1, ula_operando2, ula_tag}, 0);
        chk("reset_ocupadas", ocupadas, 0);
        reset_n = 1;
        issue(0, 16'h0003, 0, 16'h0004, 0, 1);
        tick();
        idle();
        repeat (3) tick();
        chk("basic_ocupadas", ocupadas, 0);
        issue(1, 16'h0000, 5, 16'h0010, 0, 2);
        tick();
        idle();
        repeat (2) tick();
        bcast(5, 16'h0020);
        tick();
        idle();
        repeat (3) tick();
        issue(2, 16'h1111, 0, 16'h0000, 2, 3);
        bcast(2, 16'hBEEF);
        tick();
        idle();
        repeat (3) tick();
        ula_pronto = 0;
        for (int i = 0; i < 5; i++) begin
            issue(4'(3 + i), 16'(i), 7, 16'(2 * i), 0, 3'(i + 1));
            tick();
        end
        idle();
        chk("full_ocupadas", ocupadas, 4);
        chk("full_emite_pronto", emite_pronto, 0);
        bcast(7, 16'h0077);
        tick();
        idle();
        repeat (3) tick();
        ula_pronto = 1;
        repeat (6) tick();
        ula_pronto = 0;
        for (int i = 0; i < 5; i++) begin
            issue(4'(8 + i), 16'(16 * i), 0, 16'(i + 9), 0, 3'(i + 2));
            tick();
        end
        idle();
        tick();
        chk("simul_full", ocupadas, 4);
        ula_pronto = 1;
        issue(4'hE, 16'hCAFE, 0, 16'hF00D, 0, 6);
        tick();
        tick();
        idle();
        repeat (8) tick();
        ula_pronto = 0;
        for (int i = 0; i < 4; i++) begin
            issue(4'(i), 16'(i + 40), 0, 16'(i + 50), 0, 3'(i + 1));
            tick();
        end
        idle();
        tick();
        chk("pre_reset_valid", ula_valido, 1);
        chk("pre_reset_ocupadas", ocupadas, 3);
        reset_n = 0;
        tick();
        chk("midreset_valid", ula_valido, 0);
        chk("midreset_ocupadas", ocupadas, 0);
        chk("midreset_emite_pronto", emite_pronto, 1);
        reset_n = 1;
        for (int c = 0; c < 4000; c++) begin
            emite_valido = $urandom_range(0, 1) == 1;
            emite_codop = 4'($urandom);
            emite_vj = 16'($urandom);
            emite_vk = 16'($urandom);
            emite_qj = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            emite_qk = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            emite_tag = 3'($urandom_range(1, 7));
            cdb_valido = $urandom_range(0, 1) == 1;
            cdb_tag = 3'($urandom);
            cdb_dado = 16'($urandom);
            ula_pronto = $urandom_range(0, 3) != 0;
            reset_n = $urandom_range(0, 499) != 0;
            tick();
        end
        idle();
        reset_n = 1;
        ula_pronto = 1;
        for (int t = 1; t < 8; t++) begin
            bcast(3'(t), 16'(t));
            tick();
        end
        idle();
        repeat (10) tick();
        chk("drain_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
